// File: rtl/mcu_port_pkg.sv
// Shared types and constants for the MCU port channel arbiter.
// Pure definitions: no logic, no latency, no flow control.
package mcu_port_pkg;

  localparam logic [7:0] PORT_IDX_AUTO    = 8'hFF;
  localparam int         PORT_MAX         = 8;
  localparam int         IDX_W            = 3;
  localparam logic [7:0] PORT_TYPE_SERIAL = 8'd0;

  typedef struct packed {
    logic [23:0] bitrate;
    logic [7:0]  framing;
  } port_status_t;

endpackage

// File: rtl/mcu_port_rr_pick.sv
// Combinational round-robin picker: the first set req at or after start, wrapping.
// Zero latency; no flow control.
module mcu_port_rr_pick
  import mcu_port_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  logic             hi_hit;
  logic             lo_hit;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;

  // Descending scan, so the last match written is the lowest index in each half.
  always_comb begin
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (IDX_W'(i) >= start) begin
          hi_hit = 1'b1;
          hi_idx = IDX_W'(i);
        end else begin
          lo_hit = 1'b1;
          lo_idx = IDX_W'(i);
        end
      end
    end
    hit = hi_hit | lo_hit;
    idx = hi_hit ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/mcu_port_arbiter.sv
// Shares the MCU port channel among NUM_PORTS byte ports; muxes and strobes are registered (1 cycle).
// Strobes to an empty/full or unselected port are dropped; MCU_PORT_ARB_DROP_CNT_EN adds per-port drop counters.
module mcu_port_arbiter
  import mcu_port_pkg::*;
#(
  parameter int NUM_PORTS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    host_idx_valid,
  input  logic [7:0]              host_idx,
  input  logic                    host_out_strobe,
  input  logic                    host_in_strobe,
  input  logic [7:0]              host_in_data,
  output logic                    host_sel_valid,
  output logic [7:0]              host_cur_idx,
  output logic [7:0]              host_out_available,
  output logic [7:0]              host_in_available,
  output logic [7:0]              host_out_data,
  output logic [31:0]             host_status,
  output logic [NUM_PORTS-1:0]    host_pending,
  output logic                    host_irq,
  output logic [7:0]              host_drop_cnt,
  input  logic [8*NUM_PORTS-1:0]  port_out_available,
  input  logic [8*NUM_PORTS-1:0]  port_out_data,
  input  logic [8*NUM_PORTS-1:0]  port_in_available,
  input  logic [32*NUM_PORTS-1:0] port_status,
  output logic [NUM_PORTS-1:0]    port_out_strobe,
  output logic [NUM_PORTS-1:0]    port_in_strobe,
  output logic [7:0]              port_in_data
);

  logic [7:0]   out_av  [PORT_MAX];
  logic [7:0]   out_dat [PORT_MAX];
  logic [7:0]   in_av   [PORT_MAX];
  port_status_t status  [PORT_MAX];

  // Pad unused slots with zero so a 3-bit select can always index safely.
  for (genvar g = 0; g < PORT_MAX; g++) begin : g_unpack
    if (g < NUM_PORTS) begin : g_used
      assign out_av[g]  = port_out_available[8*g +: 8];
      assign out_dat[g] = port_out_data[8*g +: 8];
      assign in_av[g]   = port_in_available[8*g +: 8];
      assign status[g]  = port_status_t'(port_status[32*g +: 32]);
    end else begin : g_pad
      assign out_av[g]  = '0;
      assign out_dat[g] = '0;
      assign in_av[g]   = '0;
      assign status[g]  = '0;
    end
  end

  logic [IDX_W-1:0]     sel_q, sel_d, last_auto_q, last_auto_d, rr_start, rr_idx;
  logic                 sel_valid_q, sel_valid_d, rr_hit, sel_take, out_ok, in_ok;
  logic [NUM_PORTS-1:0] pending_q, pending_d, nz_q, nz_now, pend_clr;
  logic [NUM_PORTS-1:0] out_stb_q, out_stb_d, in_stb_q, in_stb_d;
  logic [7:0]           in_data_q, in_data_d, oav_q, iav_q, odat_q;
  logic [31:0]          status_q;

  assign rr_start = (last_auto_q == IDX_W'(NUM_PORTS - 1)) ? '0 : last_auto_q + 1'b1;

  mcu_port_rr_pick #(.N(NUM_PORTS)) u_rr_pick (
    .req   (pending_q),
    .start (rr_start),
    .hit   (rr_hit),
    .idx   (rr_idx)
  );

  always_comb begin
    sel_d       = sel_q;
    sel_valid_d = sel_valid_q;
    last_auto_d = last_auto_q;
    sel_take    = 1'b0;
    if (host_idx_valid) begin
      if (host_idx < 8'(NUM_PORTS)) begin
        sel_d       = host_idx[IDX_W-1:0];
        sel_valid_d = 1'b1;
        sel_take    = 1'b1;
      end else if (host_idx == PORT_IDX_AUTO) begin
        sel_valid_d = rr_hit;
        if (rr_hit) begin
          sel_d       = rr_idx;
          last_auto_d = rr_idx;
          sel_take    = 1'b1;
        end
      end else begin
        sel_valid_d = 1'b0;
      end
    end
  end

  // Strobes act on the selection held before any same-cycle reselect.
  assign out_ok    = host_out_strobe && sel_valid_q && (out_av[sel_q] != 8'd0);
  assign in_ok     = host_in_strobe  && sel_valid_q && (in_av[sel_q]  != 8'd0);
  assign in_data_d = in_ok ? host_in_data : in_data_q;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign nz_now[g]    = (out_av[g] != 8'd0);
    assign pend_clr[g]  = sel_take && (sel_d == IDX_W'(g));
    assign out_stb_d[g] = out_ok && (sel_q == IDX_W'(g));
    assign in_stb_d[g]  = in_ok  && (sel_q == IDX_W'(g));
  end

  assign pending_d = (pending_q & ~pend_clr) | (nz_now & ~nz_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
      last_auto_q <= IDX_W'(NUM_PORTS - 1);
      pending_q   <= '0;
      nz_q        <= '0;
      out_stb_q   <= '0;
      in_stb_q    <= '0;
      in_data_q   <= '0;
      oav_q       <= '0;
      iav_q       <= '0;
      odat_q      <= '0;
      status_q    <= '0;
    end else begin
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
      last_auto_q <= last_auto_d;
      pending_q   <= pending_d;
      nz_q        <= nz_now;
      out_stb_q   <= out_stb_d;
      in_stb_q    <= in_stb_d;
      in_data_q   <= in_data_d;
      oav_q       <= sel_valid_d ? out_av[sel_d]  : '0;
      iav_q       <= sel_valid_d ? in_av[sel_d]   : '0;
      odat_q      <= sel_valid_d ? out_dat[sel_d] : '0;
      status_q    <= sel_valid_d ? status[sel_d]  : '0;
    end
  end

`ifdef MCU_PORT_ARB_DROP_CNT_EN
  logic [1:0] drop_inc;
  logic [7:0] drop_nxt [PORT_MAX];
  logic [7:0] host_drop_q;

  assign drop_inc = {1'b0, host_out_strobe && sel_valid_q && !out_ok}
                  + {1'b0, host_in_strobe  && sel_valid_q && !in_ok};

  for (genvar g = 0; g < PORT_MAX; g++) begin : g_drop
    logic [7:0] cnt_q, cnt_d;
    logic [8:0] sum;
    assign sum   = {1'b0, cnt_q} + ((sel_q == IDX_W'(g)) ? {7'b0, drop_inc} : 9'd0);
    assign cnt_d = (sel_take && (sel_d == IDX_W'(g))) ? 8'h00 : (sum[8] ? 8'hFF : sum[7:0]);
    assign drop_nxt[g] = cnt_d;
    always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) host_drop_q <= '0;
    else       host_drop_q <= sel_valid_d ? drop_nxt[sel_d] : '0;
  end

  assign host_drop_cnt = host_drop_q;
`else
  assign host_drop_cnt = 8'h00;
`endif

  assign host_sel_valid     = sel_valid_q;
  assign host_cur_idx       = {{(8-IDX_W){1'b0}}, sel_q};
  assign host_out_available = oav_q;
  assign host_in_available  = iav_q;
  assign host_out_data      = odat_q;
  assign host_status        = status_q;
  assign host_pending       = pending_q;
  assign host_irq           = |pending_q;
  assign port_out_strobe    = out_stb_q;
  assign port_in_strobe     = in_stb_q;
  assign port_in_data       = in_data_q;

endmodule

// File: tb/tb_mcu_port_arbiter.sv
// Randomized and directed bench for mcu_port_arbiter against a cycle-level behavioural model.
module tb_mcu_port_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  logic host_idx_valid, host_out_strobe, host_in_strobe;
  logic [7:0] host_idx, host_in_data;
  logic host_sel_valid, host_irq;
  logic [7:0] host_cur_idx, host_out_available, host_in_available, host_out_data, host_drop_cnt;
  logic [31:0] host_status;
  logic [N-1:0] host_pending, port_out_strobe, port_in_strobe;
  logic [7:0] port_in_data;
  logic [8*N-1:0] port_out_available, port_out_data, port_in_available;
  logic [32*N-1:0] port_status;

  logic [7:0]  av_out [N];
  logic [7:0]  dat_out[N];
  logic [7:0]  av_in  [N];
  logic [31:0] st     [N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign port_out_available[8*g +: 8] = av_out[g];
    assign port_out_data[8*g +: 8]      = dat_out[g];
    assign port_in_available[8*g +: 8]  = av_in[g];
    assign port_status[32*g +: 32]      = st[g];
  end

  always #5 clk = ~clk;

  mcu_port_arbiter #(.NUM_PORTS(N)) dut (
    .clk(clk), .reset(reset),
    .host_idx_valid(host_idx_valid), .host_idx(host_idx),
    .host_out_strobe(host_out_strobe), .host_in_strobe(host_in_strobe), .host_in_data(host_in_data),
    .host_sel_valid(host_sel_valid), .host_cur_idx(host_cur_idx),
    .host_out_available(host_out_available), .host_in_available(host_in_available),
    .host_out_data(host_out_data), .host_status(host_status),
    .host_pending(host_pending), .host_irq(host_irq), .host_drop_cnt(host_drop_cnt),
    .port_out_available(port_out_available), .port_out_data(port_out_data),
    .port_in_available(port_in_available), .port_status(port_status),
    .port_out_strobe(port_out_strobe), .port_in_strobe(port_in_strobe), .port_in_data(port_in_data)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  int m_sel, m_last;
  bit m_valid;
  bit [N-1:0] m_pend, m_nz;
  int m_drop[N];
  logic e_sel_valid;
  logic [7:0] e_cur, e_oav, e_iav, e_odat, e_drop, e_idat;
  logic [31:0] e_stat;
  logic [N-1:0] e_pend, e_ostb, e_istb;

  task automatic model_reset();
    m_sel = 0; m_last = N - 1; m_valid = 0; m_pend = '0; m_nz = '0;
    for (int i = 0; i < N; i++) m_drop[i] = 0;
    e_sel_valid = 0; e_cur = 0; e_oav = 0; e_iav = 0; e_odat = 0; e_drop = 0;
    e_idat = 0; e_stat = 0; e_pend = 0; e_ostb = 0; e_istb = 0;
  endtask

  task automatic drop_one(input int p);
    if (m_drop[p] < 255) m_drop[p] = m_drop[p] + 1;
  endtask

  task automatic model_step();
    bit [N-1:0] rise;
    int hit, start, c;
    if (reset) begin
      model_reset();
      return;
    end
    e_ostb = '0;
    e_istb = '0;
    if (host_out_strobe && m_valid) begin
      if (av_out[m_sel] != 0) e_ostb[m_sel] = 1'b1;
      else drop_one(m_sel);
    end
    if (host_in_strobe && m_valid) begin
      if (av_in[m_sel] != 0) begin
        e_istb[m_sel] = 1'b1;
        e_idat = host_in_data;
      end else drop_one(m_sel);
    end
    for (int i = 0; i < N; i++) begin
      rise[i] = (av_out[i] != 0) && !m_nz[i];
      m_nz[i] = (av_out[i] != 0);
    end
    hit = -1;
    if (host_idx_valid) begin
      if (int'(host_idx) < N) begin
        m_sel = int'(host_idx); m_valid = 1; hit = m_sel;
      end else if (host_idx == 8'hFF) begin
        m_valid = 0;
        start = m_last;
        for (int k = 1; k <= N; k++) begin
          c = (start + k) % N;
          if (m_pend[c] && !m_valid) begin
            m_valid = 1; m_sel = c; m_last = c; hit = c;
          end
        end
      end else begin
        m_valid = 0;
      end
    end
    if (hit >= 0) begin
      m_pend[hit] = 0;
      m_drop[hit] = 0;
    end
    m_pend = m_pend | rise;
    e_sel_valid = m_valid;
    e_cur  = 8'(m_sel);
    e_oav  = m_valid ? av_out[m_sel]  : 8'h00;
    e_iav  = m_valid ? av_in[m_sel]   : 8'h00;
    e_odat = m_valid ? dat_out[m_sel] : 8'h00;
    e_stat = m_valid ? st[m_sel]      : 32'h0;
    e_pend = m_pend;
`ifdef MCU_PORT_ARB_DROP_CNT_EN
    e_drop = m_valid ? 8'(m_drop[m_sel]) : 8'h00;
`else
    e_drop = 8'h00;
`endif
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    host_idx_valid = 0;
    host_out_strobe = 0;
    host_in_strobe = 0;
  endtask

  task automatic sel(input logic [7:0] idx);
    host_idx_valid = 1;
    host_idx = idx;
    step();
  endtask

  task automatic test_reset();
    reset = 1;
    av_out[0] = 8'd2;
    step();
    step();
    checks++;
    if ({host_sel_valid, host_cur_idx, host_out_available, host_pending, host_irq,
         port_out_strobe, port_in_strobe, port_in_data, host_status, host_drop_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_outputs act sv=%b idx=%h oav=%h pend=%b st=%h", host_sel_valid,
               host_cur_idx, host_out_available, host_pending, host_status);
    end
    reset = 0;
    step();
    checks++;
    if (host_pending !== 4'b0001) begin
      failures++;
      $display("FAIL reset_release_pending act=%b exp=0001", host_pending);
    end
    av_out[0] = 8'd0;
    step();
  endtask

  task automatic test_select();
    av_out[2] = 8'd3;
    dat_out[2] = 8'h41;
    sel(8'd2);
    checks++;
    if (host_out_available !== 8'd3 || host_out_data !== 8'h41 || host_sel_valid !== 1'b1) begin
      failures++;
      $display("FAIL select2 act oav=%0d dat=%h sv=%b exp oav=3 dat=41 sv=1",
               host_out_available, host_out_data, host_sel_valid);
    end
  endtask

  task automatic test_out_strobe();
    for (int n = 3; n >= 0; n--) begin
      av_out[2] = 8'(n);
      host_out_strobe = 1;
      step();
      checks++;
      if (port_out_strobe !== ((n != 0) ? 4'b0100 : 4'b0000)) begin
        failures++;
        $display("FAIL out_strobe avail=%0d act=%b exp=%b", n, port_out_strobe,
                 (n != 0) ? 4'b0100 : 4'b0000);
      end
    end
  endtask

  task automatic test_pending_auto();
    for (int i = 0; i < N; i++) av_out[i] = 0;
    step();
    for (int i = 0; i < N; i++) sel(8'(i));
    av_out[1] = 8'd4;
    av_out[3] = 8'd9;
    step();
    checks++;
    if (host_pending !== 4'b1010 || host_irq !== 1'b1) begin
      failures++;
      $display("FAIL pending_set act=%b irq=%b exp=1010 irq=1", host_pending, host_irq);
    end
    sel(8'hFF);
    checks++;
    if (host_sel_valid !== 1'b1 || host_cur_idx !== 8'd1 || host_pending !== 4'b1000) begin
      failures++;
      $display("FAIL auto_first act sv=%b idx=%0d pend=%b exp sv=1 idx=1 pend=1000",
               host_sel_valid, host_cur_idx, host_pending);
    end
    sel(8'hFF);
    checks++;
    if (host_sel_valid !== 1'b1 || host_cur_idx !== 8'd3 || host_irq !== 1'b0) begin
      failures++;
      $display("FAIL auto_second act sv=%b idx=%0d irq=%b exp sv=1 idx=3 irq=0",
               host_sel_valid, host_cur_idx, host_irq);
    end
    sel(8'hFF);
    checks++;
    if (host_sel_valid !== 1'b0 || host_irq !== 1'b0) begin
      failures++;
      $display("FAIL auto_none act sv=%b irq=%b exp sv=0 irq=0", host_sel_valid, host_irq);
    end
  endtask

  task automatic test_invalid_idx();
    av_in[3] = 8'd5;
    st[3] = 32'h1234_5678;
    sel(8'd7);
    checks++;
    if (host_sel_valid !== 1'b0 || host_out_available !== 0 || host_in_available !== 0 ||
        host_out_data !== 0 || host_status !== 0) begin
      failures++;
      $display("FAIL invalid_idx act sv=%b oav=%h iav=%h dat=%h st=%h exp all 0", host_sel_valid,
               host_out_available, host_in_available, host_out_data, host_status);
    end
    host_out_strobe = 1;
    host_in_strobe = 1;
    host_in_data = 8'h5A;
    step();
    checks++;
    if (port_out_strobe !== 0 || port_in_strobe !== 0) begin
      failures++;
      $display("FAIL invalid_strobe act out=%b in=%b exp 0", port_out_strobe, port_in_strobe);
    end
  endtask

  task automatic test_set_wins();
    av_out[0] = 8'd0;
    step();
    av_out[0] = 8'd5;
    sel(8'd0);
    checks++;
    if (host_pending[0] !== 1'b1 || host_sel_valid !== 1'b1) begin
      failures++;
      $display("FAIL set_wins act pend0=%b sv=%b exp pend0=1 sv=1", host_pending[0], host_sel_valid);
    end
  endtask

  task automatic test_drop_cnt();
    logic [7:0] exp_sat;
`ifdef MCU_PORT_ARB_DROP_CNT_EN
    exp_sat = 8'hFF;
`else
    exp_sat = 8'h00;
`endif
    av_in[1] = 8'd0;
    sel(8'd1);
    for (int n = 0; n < 300; n++) begin
      host_in_strobe = 1;
      host_in_data = 8'(n);
      step();
    end
    checks++;
    if (host_drop_cnt !== exp_sat || port_in_strobe !== 0) begin
      failures++;
      $display("FAIL drop_saturate act=%h in_stb=%b exp=%h", host_drop_cnt, port_in_strobe, exp_sat);
    end
    sel(8'd1);
    checks++;
    if (host_drop_cnt !== 8'h00) begin
      failures++;
      $display("FAIL drop_reselect act=%h exp=00", host_drop_cnt);
    end
  endtask

  task automatic test_random();
    logic [7:0] idx_tab[8];
    idx_tab = '{8'd0, 8'd1, 8'd2, 8'd3, 8'hFF, 8'hFF, 8'd5, 8'd200};
    for (int cyc = 0; cyc < 600; cyc++) begin
      reset = ($urandom_range(0, 79) == 0);
      host_idx_valid = ($urandom_range(0, 3) == 0);
      host_idx = idx_tab[$urandom_range(0, 7)];
      host_out_strobe = $urandom_range(0, 1);
      host_in_strobe = $urandom_range(0, 1);
      host_in_data = 8'($urandom);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) av_out[i] = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom);
        if ($urandom_range(0, 3) == 0) av_in[i]  = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom);
        dat_out[i] = 8'($urandom);
        st[i] = $urandom;
      end
      step();
      checks++;
      if ({host_sel_valid, host_cur_idx, host_out_available, host_in_available, host_out_data,
           host_status, host_pending, host_irq, host_drop_cnt, port_out_strobe, port_in_strobe,
           port_in_data} !==
          {e_sel_valid, e_cur, e_oav, e_iav, e_odat, e_stat, e_pend, |e_pend, e_drop, e_ostb,
           e_istb, e_idat}) begin
        failures++;
        $display("FAIL random cyc=%0d act sv=%b idx=%h oav=%h iav=%h dat=%h st=%h pend=%b drop=%h os=%b is=%b id=%h exp sv=%b idx=%h oav=%h iav=%h dat=%h st=%h pend=%b drop=%h os=%b is=%b id=%h",
                 cyc, host_sel_valid, host_cur_idx, host_out_available, host_in_available,
                 host_out_data, host_status, host_pending, host_drop_cnt, port_out_strobe,
                 port_in_strobe, port_in_data, e_sel_valid, e_cur, e_oav, e_iav, e_odat, e_stat,
                 e_pend, e_drop, e_ostb, e_istb, e_idat);
      end
    end
    reset = 0;
  endtask

  initial begin
    reset = 1;
    host_idx_valid = 0; host_idx = 0; host_out_strobe = 0; host_in_strobe = 0; host_in_data = 0;
    for (int i = 0; i < N; i++) begin
      av_out[i] = 0; dat_out[i] = 0; av_in[i] = 0; st[i] = 0;
    end
    model_reset();
    test_reset();
    test_select();
    test_out_strobe();
    test_pending_auto();
    test_invalid_idx();
    test_set_wins();
    test_drop_cnt();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
